// File: rtl/delay_countdown_timer.sv
// Delay countdown timer: captures a WIDTH-bit delay D from the serial stream
// once the start pattern is found, counts (D+1)*CYCLES_PER_UNIT cycles while
// exposing the remaining units, then holds done until ack and pulses rearm.
module delay_countdown_timer #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned CYCLES_PER_UNIT = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             data,
   input  logic             start_shifting,
   input  logic             ack,
   output logic             shift_ena,
   output logic             counting,
   output logic [WIDTH-1:0] count,
   output logic             done,
   output logic             rearm
);

   localparam int unsigned BITCNT_W = $clog2(WIDTH + 1);
   localparam int unsigned SUBCNT_W = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
   localparam logic [SUBCNT_W-1:0] SUB_RELOAD = SUBCNT_W'(CYCLES_PER_UNIT - 1);
   localparam logic [BITCNT_W-1:0] BIT_LAST   = BITCNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COUNT,
      ST_DONE
   } state_t;

   state_t              state_q,   state_d;
   logic [WIDTH-1:0]    shreg_q,   shreg_d;
   logic [BITCNT_W-1:0] bitcnt_q,  bitcnt_d;
   logic [WIDTH-1:0]    unitcnt_q, unitcnt_d;
   logic [SUBCNT_W-1:0] subcnt_q,  subcnt_d;
   logic                rearm_q,   rearm_d;

   logic [WIDTH:0]      shift_word;
   logic [WIDTH-1:0]    shifted;

   // Shift register value with the current serial bit appended (MSB first).
   always_comb begin
      shift_word = {shreg_q, data};
      shifted    = shift_word[WIDTH-1:0];
   end

   // Next-state and output decode for the capture / countdown / done FSM.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      unitcnt_d = unitcnt_q;
      subcnt_d  = subcnt_q;
      rearm_d   = 1'b0;
      shift_ena = 1'b0;
      counting  = 1'b0;
      count     = '0;
      done      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // While rearm is high the detector has not yet been cleared,
            // so its still-high start level must not retrigger a capture.
            if (start_shifting && !rearm_q) begin
               shift_ena = 1'b1;
               shreg_d   = shifted;
               bitcnt_d  = BITCNT_W'(1);
               if (WIDTH == 1) begin
                  state_d   = ST_COUNT;
                  unitcnt_d = shifted;
                  subcnt_d  = SUB_RELOAD;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end

         ST_SHIFT: begin
            shift_ena = 1'b1;
            shreg_d   = shifted;
            bitcnt_d  = bitcnt_q + BITCNT_W'(1);
            if (bitcnt_q == BIT_LAST) begin
               state_d   = ST_COUNT;
               unitcnt_d = shifted;
               subcnt_d  = SUB_RELOAD;
            end
         end

         ST_COUNT: begin
            counting = 1'b1;
            count    = unitcnt_q;
            if (subcnt_q != '0) begin
               subcnt_d = subcnt_q - SUBCNT_W'(1);
            end else if (unitcnt_q != '0) begin
               unitcnt_d = unitcnt_q - WIDTH'(1);
               subcnt_d  = SUB_RELOAD;
            end else begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            done = 1'b1;
            if (ack) begin
               state_d = ST_IDLE;
               rearm_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
         unitcnt_q <= '0;
         subcnt_q  <= '0;
         rearm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
         unitcnt_q <= unitcnt_d;
         subcnt_q  <= subcnt_d;
         rearm_q   <= rearm_d;
      end
   end

   assign rearm = rearm_q;

endmodule

// File: tb/tb_delay_countdown_timer.sv
// Self-checking bench for delay_countdown_timer (WIDTH=4, CYCLES_PER_UNIT=4).
module tb_delay_countdown_timer;

   localparam int W   = 4;
   localparam int CPU = 4;

   logic         clk = 1'b0;
   logic         reset, data, start_shifting, ack;
   logic         shift_ena, counting, done, rearm;
   logic [W-1:0] count;

   delay_countdown_timer #(
      .WIDTH          (W),
      .CYCLES_PER_UNIT(CPU)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .data          (data),
      .start_shifting(start_shifting),
      .ack           (ack),
      .shift_ena     (shift_ena),
      .counting      (counting),
      .count         (count),
      .done          (done),
      .rearm         (rearm)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: phase plus "cycles left in the countdown".
   // phase 0 idle, 1 collecting bits, 2 counting, 3 waiting for ack.
   int m_phase;
   int m_bits[$];
   int m_left;
   bit m_rearm;
   bit m_valid = 1'b0;

   // Outputs sampled in the most recent step.
   logic         s_shift, s_counting, s_done, s_rearm;
   logic [W-1:0] s_count;

   typedef struct packed {
      logic         r, d, s, a;
      logic         e_shift, e_counting;
      logic [W-1:0] e_count;
      logic         e_done, e_rearm;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input bit r, input bit d, input bit s, input bit a);
      bit new_rearm;
      int dv;
      new_rearm = 1'b0;
      if (r) begin
         m_phase = 0;
         m_bits.delete();
         m_left  = 0;
         m_rearm = 1'b0;
      end else begin
         case (m_phase)
            0, 1: begin
               if (m_phase == 1 || (s && !m_rearm)) begin
                  m_bits.push_back(int'(d));
                  m_phase = 1;
                  if (m_bits.size() == W) begin
                     dv = 0;
                     foreach (m_bits[i]) dv = dv * 2 + m_bits[i];
                     m_bits.delete();
                     m_left  = (dv + 1) * CPU;
                     m_phase = 2;
                  end
               end
            end
            2: begin
               m_left--;
               if (m_left == 0) m_phase = 3;
            end
            default: begin
               if (a) begin
                  m_phase   = 0;
                  new_rearm = 1'b1;
               end
            end
         endcase
         m_rearm = new_rearm;
      end
   endtask

   // One clock cycle: drive, sample at negedge, compare against model, advance.
   task automatic step(input bit r, input bit d, input bit s, input bit a);
      int e_count;
      reset = r; data = d; start_shifting = s; ack = a;
      @(negedge clk);
      s_shift = shift_ena; s_counting = counting; s_count = count;
      s_done = done; s_rearm = rearm;
      if (m_valid) begin
         e_count = (m_phase == 2) ? (m_left - 1) / CPU : 0;
         chk("shift_ena", int'(s_shift), int'((m_phase == 0 && s && !m_rearm) || m_phase == 1));
         chk("counting",  int'(s_counting), int'(m_phase == 2));
         chk("count",     int'(s_count), e_count);
         chk("done",      int'(s_done), int'(m_phase == 3));
         chk("rearm",     int'(s_rearm), int'(m_rearm));
      end
      @(posedge clk);
      model_update(r, d, s, a);
      #1;
   endtask

   // Trigger with delay dv (start held high), run to done; optional stray inputs.
   task automatic run_delay(input logic [W-1:0] dv, input bit stray);
      int  ns, nc, n;
      bit  seen;
      ns = 0; nc = 0; seen = 1'b0;
      n  = (int'(dv) + 1) * CPU;
      for (int i = 0; i < W; i++) begin
         step(1'b0, dv[W-1-i], 1'b1, stray && (i == 1));
         if (s_shift) ns++;
      end
      for (int i = 0; i < 200 && !seen; i++) begin
         step(1'b0, stray ? 1'($urandom % 2) : 1'b0, 1'b1,
              stray && (i < n) && ((i % 5) == 0));
         if (s_counting) nc++;
         if (s_done) seen = 1'b1;
      end
      chk("shift_cycles", ns, W);
      chk("count_cycles", nc, n);
      chk("done_reached", int'(seen), 1);
   endtask

   // Hold done for some cycles, ack, check single rearm pulse with start held.
   task automatic ack_seq(input int hold);
      for (int i = 0; i < hold; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         chk("done_held", int'(s_done), 1);
      end
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("rearm_pulse", int'(s_rearm), 1);
      chk("no_capture_in_rearm", int'(s_shift), 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rearm_cleared", int'(s_rearm), 0);
   endtask

   initial begin
      // {r,d,s,a, shift,counting,count,done,rearm}: D=0 capture, done, ack.
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd0,1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'd0,1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,4'd0,1'b0,1'b0};
      tbl[3]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,4'd0,1'b0,1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,4'd0,1'b0,1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,4'd0,1'b0,1'b0};
      tbl[6]  = '{1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,4'd0,1'b0,1'b0};
      tbl[7]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,4'd0,1'b0,1'b0};
      tbl[8]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,4'd0,1'b0,1'b0};
      tbl[9]  = '{1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,4'd0,1'b0,1'b0};
      tbl[10] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,4'd0,1'b1,1'b0};
      tbl[11] = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,4'd0,1'b1,1'b0};
      tbl[12] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,4'd0,1'b0,1'b1};
      tbl[13] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd0,1'b0,1'b0};

      reset = 1'b1; data = 1'b0; start_shifting = 1'b0; ack = 1'b0;
      @(posedge clk); #1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      m_valid = 1'b1;

      // Table-driven D=0 sequence.
      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].d, tbl[i].s, tbl[i].a);
         chk("tbl_shift",    int'(s_shift),    int'(tbl[i].e_shift));
         chk("tbl_counting", int'(s_counting), int'(tbl[i].e_counting));
         chk("tbl_count",    int'(s_count),    int'(tbl[i].e_count));
         chk("tbl_done",     int'(s_done),     int'(tbl[i].e_done));
         chk("tbl_rearm",    int'(s_rearm),    int'(tbl[i].e_rearm));
      end

      // D=5, done held 10 cycles before ack.
      run_delay(4'b0101, 1'b0);
      ack_seq(10);

      // D=5 again with stray ack/data during SHIFT and COUNT.
      run_delay(4'b0101, 1'b1);
      ack_seq(0);

      // Back-to-back maximum delay.
      run_delay(4'b1111, 1'b0);
      ack_seq(0);

      // Reset for two cycles in the middle of COUNT (D=9).
      for (int i = 0; i < W; i++) step(1'b0, (i == 0 || i == 3), 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("mid_count_active", int'(s_counting), 1);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_reset_counting", int'(s_counting), 0);
      chk("post_reset_done",     int'(s_done), 0);
      chk("post_reset_count",    int'(s_count), 0);
      chk("post_reset_rearm",    int'(s_rearm), 0);
      run_delay(4'b0011, 1'b0);
      ack_seq(2);

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         step(1'(($urandom % 60) == 0), 1'($urandom % 2),
              1'(($urandom % 4) != 0), 1'(($urandom % 8) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
